dbus_if: RTL and testbench

DBUS_IF -- requirements
Module: dbus_if

---
 rtl/dbus_if_pkg.sv | 34 +++
 rtl/dbus_if_if.sv | 30 +++
 rtl/dbus_timeout_cnt.sv | 32 +++
 rtl/dbus_if.sv | 114 +++++++++++
 tb/tb_dbus_if.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_if_pkg.sv
// Shared defines for the data-bus interface unit.
// Bus word types, FSM state encoding, watchdog limit, byte lanes.
package dbus_if_pkg;

  localparam int RegBusW = 32;
  typedef logic [RegBusW-1:0] RegBus;
  localparam RegBus ZeroWord = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } dbus_state_e;

  localparam logic [7:0] DBUS_TIMEOUT = 8'd255;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_B0   = 4'b0001;
  localparam logic [3:0] SEL_B1   = 4'b0010;
  localparam logic [3:0] SEL_B2   = 4'b0100;
  localparam logic [3:0] SEL_B3   = 4'b1000;
  localparam logic [3:0] SEL_H0   = 4'b0011;
  localparam logic [3:0] SEL_H1   = 4'b1100;
  localparam logic [3:0] SEL_ALL  = 4'b1111;

  typedef struct packed {
    logic       cyc;
    logic       we;
    logic [3:0] sel;
    RegBus      addr;
    RegBus      wdata;
  } bus_req_t;

endpackage

// File: rtl/dbus_if_if.sv
// Wishbone-style data bus between dbus_if (master) and memory (slave).
// master drives cyc/stb/we/sel/addr/wdata/err; slave drives rdata/ack.
interface dbus_if_if;
  import dbus_if_pkg::*;

  logic       bus_cyc_o;
  logic       bus_stb_o;
  logic       bus_we_o;
  logic [3:0] bus_sel_o;
  RegBus      bus_addr_o;
  RegBus      bus_wdata_o;
  RegBus      bus_rdata_i;
  logic       bus_ack_i;
  logic       bus_err_o;

  modport master (
    output bus_cyc_o, bus_stb_o, bus_we_o,
    output bus_sel_o, bus_addr_o, bus_wdata_o,
    output bus_err_o,
    input  bus_rdata_i, bus_ack_i
  );

  modport slave (
    input  bus_cyc_o, bus_stb_o, bus_we_o,
    input  bus_sel_o, bus_addr_o, bus_wdata_o,
    input  bus_err_o,
    output bus_rdata_i, bus_ack_i
  );

endinterface

// File: rtl/dbus_timeout_cnt.sv
// Watchdog for BUSY: counts BUSY cycles, flags the DBUS_TIMEOUT-th one.
// Ports: clk, rst, busy_i, clr_i (ack/flush), expired_o.
module dbus_timeout_cnt
  import dbus_if_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  input  logic clr_i,
  output logic expired_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // cnt_q holds the BUSY cycles already elapsed, so the
  // current cycle is number cnt_q+1.
  assign expired_o = busy_i &&
    (cnt_q == DBUS_TIMEOUT - 8'd1);

  always_comb begin
    cnt_d = 8'd0;
    if (busy_i && !clr_i && !expired_o)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dbus_if.sv
// Data-bus interface: turns MEM-stage loads/stores into bus cycles.
// Ports: clk, rst, mem_* request, stall_i/flush_i/stallreq_o, bus (master).
// Optional watchdog abort enabled by macro DBUS_TIMEOUT_EN.
module dbus_if
  import dbus_if_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_ce_i,
  input  logic       mem_we_i,
  input  logic [3:0] mem_sel_i,
  input  RegBus      mem_addr_i,
  input  RegBus      mem_wdata_i,
  output RegBus      mem_rdata_o,
  input  logic       stall_i,
  input  logic       flush_i,
  output logic       stallreq_o,
  dbus_if_if.master  bus
);

  dbus_state_e state_q;
  bus_req_t    req_q;
  RegBus       rd_buf_q;
  logic        tmo;

`ifdef DBUS_TIMEOUT_EN
  logic busy;
  logic tmo_raw;

  assign busy = (state_q == BUSY);

  dbus_timeout_cnt u_tmo (
    .clk      (clk),
    .rst      (rst),
    .busy_i   (busy),
    .clr_i    (bus.bus_ack_i | flush_i),
    .expired_o(tmo_raw)
  );

  // ack and flush both win over an expiring watchdog
  assign tmo = tmo_raw && !bus.bus_ack_i && !flush_i;
`else
  assign tmo = 1'b0;
`endif

  assign bus.bus_cyc_o   = req_q.cyc;
  assign bus.bus_stb_o   = req_q.cyc;
  assign bus.bus_we_o    = req_q.we;
  assign bus.bus_sel_o   = req_q.sel;
  assign bus.bus_addr_o  = req_q.addr;
  assign bus.bus_wdata_o = req_q.wdata;
  assign bus.bus_err_o   = tmo;

  // rst gates these too so a held mem_ce_i cannot leak
  // a stall request while the block is in reset.
  always_comb begin
    stallreq_o  = 1'b0;
    mem_rdata_o = ZeroWord;
    if (!rst && !flush_i) begin
      unique case (state_q)
        IDLE: stallreq_o = mem_ce_i;
        BUSY: begin
          stallreq_o = !(bus.bus_ack_i || tmo);
          if (bus.bus_ack_i && !req_q.we)
            mem_rdata_o = bus.bus_rdata_i;
        end
        HOLD: mem_rdata_o = rd_buf_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      rd_buf_q <= ZeroWord;
    end else if (flush_i) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_ce_i) begin
            req_q <= '{
              cyc:   1'b1,
              we:    mem_we_i,
              sel:   mem_sel_i,
              addr:  mem_addr_i,
              wdata: mem_wdata_i
            };
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (bus.bus_ack_i || tmo) begin
            req_q <= '0;
            if (bus.bus_ack_i && !req_q.we)
              rd_buf_q <= bus.bus_rdata_i;
            state_q <= stall_i ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (!stall_i) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_if.sv
// Self-checking bench for dbus_if: behavioural model + directed vectors.
// Honours DBUS_TIMEOUT_EN for the watchdog scenario.
module tb_dbus_if;
  import dbus_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        stall_i;
  logic        flush_i;
  logic        stallreq_o;

  int vectors = 0;
  int miscompares = 0;

`ifdef DBUS_TIMEOUT_EN
  localparam int TO_WAIT = 300;
`else
  localparam int TO_WAIT = 20;
`endif

  dbus_if_if bus();

  dbus_if dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ce_i   (mem_ce_i),
    .mem_we_i   (mem_we_i),
    .mem_sel_i  (mem_sel_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .stallreq_o (stallreq_o),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: one access in flight (m_busy), or a finished load
  // being held for a stalled pipeline (m_hold).
  logic        m_busy = 0;
  logic        m_hold = 0;
  logic        m_we = 0;
  logic [3:0]  m_sel = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_wdata = 0;
  logic [31:0] m_buf = 0;
  int          m_tcnt = 0;

  always @(negedge clk) begin : cmp
    logic b, h, ack, to, e_stall;
    logic [31:0] e_rd;
    logic nb, nh, nwe;
    logic [3:0] nsel;
    logic [31:0] nbuf, naddr, nwd;
    int ntc;
    b = m_busy && !rst;
    h = m_hold && !rst;
    ack = bus.bus_ack_i;
    to = 1'b0;
`ifdef DBUS_TIMEOUT_EN
    to = b && !ack && !flush_i && (m_tcnt + 1 == 255);
`endif
    e_stall = 1'b0;
    e_rd = 32'h0;
    if (!rst && !flush_i) begin
      if (b) begin
        e_stall = !(ack || to);
        if (ack && !m_we) e_rd = bus.bus_rdata_i;
      end else if (h) begin
        e_rd = m_buf;
      end else begin
        e_stall = mem_ce_i;
      end
    end
    chk("stallreq", stallreq_o, e_stall);
    chk("mem_rdata", mem_rdata_o, e_rd);
    chk("bus_err", bus.bus_err_o, to);
    chk("bus_cyc", bus.bus_cyc_o, b);
    chk("bus_stb", bus.bus_stb_o, b);
    chk("bus_we", bus.bus_we_o, b & m_we);
    chk("bus_sel", bus.bus_sel_o, b ? m_sel : 4'h0);
    chk("bus_addr", bus.bus_addr_o, b ? m_addr : 0);
    chk("bus_wdata", bus.bus_wdata_o, b ? m_wdata : 0);

    nb = b; nh = h; nbuf = m_buf; ntc = 0;
    nwe = m_we; nsel = m_sel;
    naddr = m_addr; nwd = m_wdata;
    if (rst) begin
      nb = 0; nh = 0; nbuf = 0;
    end else if (flush_i) begin
      nb = 0; nh = 0;
    end else if (b) begin
      if (ack || to) begin
        nb = 0;
        nh = stall_i;
        if (ack && !m_we) nbuf = bus.bus_rdata_i;
      end else begin
        ntc = m_tcnt + 1;
      end
    end else if (h) begin
      if (!stall_i) nh = 0;
    end else if (mem_ce_i) begin
      nb = 1;
      nwe = mem_we_i; nsel = mem_sel_i;
      naddr = mem_addr_i; nwd = mem_wdata_i;
    end
    m_busy <= nb;
    m_hold <= nh;
    m_buf <= nbuf;
    m_tcnt <= ntc;
    m_we <= nwe;
    m_sel <= nsel;
    m_addr <= naddr;
    m_wdata <= nwd;
  end

  task automatic req(input logic we, input logic [3:0] sel,
                     input logic [31:0] addr,
                     input logic [31:0] wd);
    mem_ce_i = 1; mem_we_i = we; mem_sel_i = sel;
    mem_addr_i = addr; mem_wdata_i = wd;
  endtask

  initial begin
    int span;
    int errc;
    rst = 1; stall_i = 0; flush_i = 0;
    req(1'b0, SEL_ALL, 32'h100, 32'h0);
    bus.bus_ack_i = 0; bus.bus_rdata_i = 32'h0;
    @(negedge clk);
    chk("rst_stall", stallreq_o, 0);
    chk("rst_cyc", bus.bus_cyc_o, 0);
    chk("rst_rdata", mem_rdata_o, 0);
    tick(); rst = 0; mem_ce_i = 0;

    // load, ack 3 cycles after the request
    tick(); req(1'b0, SEL_ALL, 32'h100, 32'h0);
    span = 0;
    for (int c = 0; c < 20; c++) begin
      bus.bus_ack_i = (c == 3);
      bus.bus_rdata_i = (c == 3) ? 32'hDEADBEEF : 32'hBAD0BAD0;
      @(negedge clk);
      span++;
      if (!stallreq_o) break;
      tick();
    end
    chk("load_span", span, 4);
    chk("load_rdata", mem_rdata_o, 32'hDEADBEEF);
    tick(); mem_ce_i = 0; bus.bus_ack_i = 0;
    @(negedge clk);
    chk("load_cyc_after", bus.bus_cyc_o, 0);

    // store, ack on first BUSY cycle
    tick(); req(1'b1, SEL_B1, 32'h204, 32'h00AB00AB);
    @(negedge clk);
    chk("st_req_stall", stallreq_o, 1);
    tick(); bus.bus_ack_i = 1; bus.bus_rdata_i = 32'h5555AAAA;
    @(negedge clk);
    chk("st_sel", bus.bus_sel_o, 4'b0010);
    chk("st_we", bus.bus_we_o, 1);
    chk("st_wdata", bus.bus_wdata_o, 32'h00AB00AB);
    chk("st_ack_stall", stallreq_o, 0);
    chk("st_rdata", mem_rdata_o, 0);
    tick(); mem_ce_i = 0; bus.bus_ack_i = 0;
    @(negedge clk);
    chk("st_we_after", bus.bus_we_o, 0);

    // load completing under an external stall -> HOLD
    tick(); req(1'b0, SEL_ALL, 32'h300, 32'h0);
    bus.bus_rdata_i = 32'hBAD0BAD0;
    @(negedge clk);
    tick(); bus.bus_ack_i = 1;
    bus.bus_rdata_i = 32'h12345678; stall_i = 1;
    @(negedge clk);
    chk("hold_ack_rdata", mem_rdata_o, 32'h12345678);
    for (int c = 0; c < 3; c++) begin
      tick(); bus.bus_ack_i = 0;
      bus.bus_rdata_i = 32'hBAD0BAD0;
      stall_i = (c < 2);
      @(negedge clk);
      chk("hold_rdata", mem_rdata_o, 32'h12345678);
      chk("hold_cyc", bus.bus_cyc_o, 0);
      chk("hold_stall", stallreq_o, 0);
    end
    tick(); mem_ce_i = 0; stall_i = 0;
    @(negedge clk);
    chk("hold_exit_rdata", mem_rdata_o, 0);

    // flush in second BUSY cycle, late ack ignored
    tick(); req(1'b0, SEL_ALL, 32'h400, 32'h0);
    @(negedge clk);
    tick(); @(negedge clk);
    chk("fl_busy_cyc", bus.bus_cyc_o, 1);
    tick(); flush_i = 1;
    @(negedge clk);
    chk("fl_stall", stallreq_o, 0);
    chk("fl_rdata", mem_rdata_o, 0);
    tick(); flush_i = 0; mem_ce_i = 0;
    bus.bus_ack_i = 1; bus.bus_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    chk("fl_cyc_after", bus.bus_cyc_o, 0);
    chk("fl_ack_rdata", mem_rdata_o, 0);
    tick(); bus.bus_ack_i = 0;
    // flush beats a new request
    req(1'b0, SEL_ALL, 32'h480, 32'h0); flush_i = 1;
    @(negedge clk);
    chk("fl_req_stall", stallreq_o, 0);
    tick(); flush_i = 0; mem_ce_i = 0;
    @(negedge clk);
    chk("fl_req_cyc", bus.bus_cyc_o, 0);

    // reset mid-BUSY, then a clean load
    tick(); req(1'b0, SEL_ALL, 32'h500, 32'h0);
    @(negedge clk);
    tick(); @(negedge clk);
    chk("rb_cyc", bus.bus_cyc_o, 1);
    #2 rst = 1;
    #1;
    chk("rb_cyc_now", bus.bus_cyc_o, 0);
    chk("rb_addr_now", bus.bus_addr_o, 0);
    chk("rb_stall_now", stallreq_o, 0);
    tick(); @(negedge clk);
    tick(); rst = 0;
    req(1'b0, SEL_ALL, 32'h600, 32'h0);
    @(negedge clk);
    chk("ra_stall", stallreq_o, 1);
    tick(); bus.bus_ack_i = 1; bus.bus_rdata_i = 32'h600D600D;
    @(negedge clk);
    chk("ra_rdata", mem_rdata_o, 32'h600D600D);
    tick(); bus.bus_ack_i = 0; mem_ce_i = 0;
    @(negedge clk);
    chk("ra_cyc_after", bus.bus_cyc_o, 0);

    // no ack: watchdog abort, or an indefinite wait
    tick(); req(1'b0, SEL_ALL, 32'h700, 32'h0);
    bus.bus_rdata_i = 32'hBAD0BAD0;
    @(negedge clk);
    errc = 0;
    for (int c = 1; c <= TO_WAIT; c++) begin
      tick(); @(negedge clk);
      if (bus.bus_err_o) begin
        errc = c;
        break;
      end
    end
`ifdef DBUS_TIMEOUT_EN
    chk("to_cycle", errc, 255);
    chk("to_stall", stallreq_o, 0);
    chk("to_rdata", mem_rdata_o, 0);
`else
    chk("no_to_err", errc, 0);
    chk("wait_stall", stallreq_o, 1);
    chk("wait_cyc", bus.bus_cyc_o, 1);
`endif
    tick(); mem_ce_i = 0; flush_i = 1;
    @(negedge clk);
    tick(); flush_i = 0;
    @(negedge clk);
    chk("end_cyc", bus.bus_cyc_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
